// File: rtl/icache_if.sv
// icache_if: fetch-side and backing-memory signals of the instruction cache
interface icache_if;
  logic [15:0] fetch_addr;
  logic        inval;
  logic [15:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  modport slave (
    input  fetch_addr, inval, mem_ack, mem_data,
    output instr, instr_valid, stall, mem_req, mem_addr
  );
  modport master (
    output fetch_addr, inval, mem_ack, mem_data,
    input  instr, instr_valid, stall, mem_req, mem_addr
  );
endinterface

// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache with whole-line fill over a req/ack handshake
module icache #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  icache_if.slave  bus
);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = 16 - OW - IW;
  typedef enum logic {LOOKUP, FILL} state_t;
  state_t               state_q, state_d;
  logic [15:0]          raddr_q, raddr_d;
  logic [OW-1:0]        cnt_q, cnt_d;
  logic                 primed_q;
  logic                 inval_seen_q, inval_seen_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TW-1:0]        tag_q  [NUM_LINES];
  logic [TW-1:0]        tag_d  [NUM_LINES];
  logic [15:0]          data_q [NUM_LINES*LINE_WORDS];
  logic [15:0]          data_d [NUM_LINES*LINE_WORDS];
  logic [TW-1:0]        rtag;
  logic [IW-1:0]        idx;
  logic [OW-1:0]        off;
  logic                 hit, stall, ack, last;
  assign {rtag, idx, off} = raddr_q;
  assign hit   = valid_q[idx] && tag_q[idx] == rtag && state_q == LOOKUP;
  assign stall = primed_q && !hit;
  assign ack   = state_q == FILL && bus.mem_ack;
  assign last  = ack && cnt_q == '1;
  assign bus.stall       = stall;
  assign bus.instr_valid = primed_q && hit;
  assign bus.instr       = (primed_q && hit) ? data_q[{idx, off}] : '0;
  assign bus.mem_req     = state_q == FILL;
  assign bus.mem_addr    = state_q == FILL ? {rtag, idx, cnt_q} : '0;
  // Next-state: address capture, miss detection, line fill and invalidation
  always_comb begin
    state_d      = state_q;
    raddr_d      = stall ? raddr_q : bus.fetch_addr;
    cnt_d        = cnt_q;
    inval_seen_d = inval_seen_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    data_d       = data_q;
    if (state_q == LOOKUP && stall) begin
      state_d      = FILL;
      cnt_d        = '0;
      inval_seen_d = 1'b0;
    end
    if (ack) begin
      data_d[{idx, cnt_q}] = bus.mem_data;
      cnt_d                = cnt_q + 1'b1;
    end
    if (last) begin
      tag_d[idx]   = rtag;
      valid_d[idx] = !inval_seen_q;
      state_d      = LOOKUP;
    end
    if (bus.inval) begin
      valid_d = '0;
      if (state_q == FILL) inval_seen_d = 1'b1;
    end
  end
  // Control state; reset abandons any fill in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOOKUP;
      raddr_q      <= '0;
      cnt_q        <= '0;
      primed_q     <= 1'b0;
      inval_seen_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      raddr_q      <= raddr_d;
      cnt_q        <= cnt_d;
      primed_q     <= 1'b1;
      inval_seen_q <= inval_seen_d;
      valid_q      <= valid_d;
    end
  end
  // Tag and data storage need no reset; valid bits guard them
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end
endmodule

// File: tb/tb_icache.sv
// tb_icache: vector table, corner-case sequences and randomized accesses against a line-level model
module tb_icache;
  localparam int LW = 4;
  localparam int NL = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  icache_if bus();
  icache #(.LINE_WORDS(LW), .NUM_LINES(NL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  int waits = 0;
  int wcnt = 0;
  int hs_err = 0;
  logic last_req = 1'b0;
  logic last_ack = 1'b0;
  logic [15:0] last_addr = '0;
  logic [15:0] ackq[$];
  logic mvalid [NL];
  int   mline  [NL];
  typedef struct {logic [15:0] addr; int stalls; logic [15:0] instr;} vec_t;
  vec_t tbl [6];
  // Backing memory: data = addr ^ A5A5, 'waits' idle cycles before each ack
  always @(negedge clk) begin
    if (bus.mem_req && last_req && !last_ack && bus.mem_addr != last_addr) hs_err++;
    last_req  = bus.mem_req;
    last_addr = bus.mem_addr;
    if (!bus.mem_req) begin
      wcnt = 0;
      bus.mem_ack = 1'b0;
    end else if (wcnt >= waits) begin
      wcnt = 0;
      bus.mem_ack = 1'b1;
      ackq.push_back(bus.mem_addr);
    end else begin
      wcnt++;
      bus.mem_ack = 1'b0;
    end
    last_ack = bus.mem_ack;
    bus.mem_data = bus.mem_addr ^ 16'hA5A5;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic model_reset();
    foreach (mvalid[j]) begin
      mvalid[j] = 1'b0;
      mline[j] = -1;
    end
  endtask
  task automatic model_access(input logic [15:0] a, input logic inv, output int exp);
    int line;
    int i;
    line = int'(a) / LW;
    i = line % NL;
    if (inv) foreach (mvalid[j]) mvalid[j] = 1'b0;
    if (mvalid[i] && mline[i] == line) exp = 0;
    else begin
      mvalid[i] = 1'b1;
      mline[i] = line;
      exp = 1 + LW * (1 + waits);
    end
  endtask
  task automatic do_access(input logic [15:0] a, input logic inv, output int st,
                           output logic [15:0] d, output logic v);
    bus.fetch_addr = a;
    bus.inval = inv;
    @(posedge clk); #1;
    bus.inval = 1'b0;
    st = 0;
    while (bus.stall && st < 400) begin
      @(posedge clk); #1;
      st++;
    end
    d = bus.instr;
    v = bus.instr_valid;
  endtask
  task automatic check_access(input string nm, input logic [15:0] a, input logic inv);
    int e, st;
    logic [15:0] d;
    logic v;
    model_access(a, inv, e);
    do_access(a, inv, st, d, v);
    chk({nm, "_stalls"}, st, e);
    chk({nm, "_instr"}, d, a ^ 16'hA5A5);
    chk({nm, "_valid"}, v, 1);
  endtask
  initial begin
    int st, n, e;
    logic [15:0] d, a;
    logic v, ok;
    logic [15:0] exp_q[$];
    tbl[0] = '{16'h0000, 5, 16'hA5A5};
    tbl[1] = '{16'h0001, 0, 16'hA5A4};
    tbl[2] = '{16'h0002, 0, 16'hA5A7};
    tbl[3] = '{16'h0003, 0, 16'hA5A6};
    tbl[4] = '{16'h0040, 5, 16'hA5E5};
    tbl[5] = '{16'h0000, 5, 16'hA5A5};
    bus.fetch_addr = '0;
    bus.inval = 1'b0;
    bus.mem_ack = 1'b0;
    bus.mem_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr", bus.instr, 0);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    #2 rst_n = 1'b1;
    #1;
    chk("first_stall", bus.stall, 0);
    chk("first_valid", bus.instr_valid, 0);
    ackq.delete();
    for (int i = 0; i < 6; i++) begin
      model_access(tbl[i].addr, 1'b0, e);
      do_access(tbl[i].addr, 1'b0, st, d, v);
      chk($sformatf("vec%0d_stalls", i), st, tbl[i].stalls);
      chk($sformatf("vec%0d_instr", i), d, tbl[i].instr);
      chk($sformatf("vec%0d_valid", i), v, 1);
    end
    exp_q = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0040, 16'h0041,
              16'h0042, 16'h0043, 16'h0000, 16'h0001, 16'h0002, 16'h0003};
    chk("fill_addr_seq", ackq == exp_q, 1);
    waits = 3;
    model_access(16'h0123, 1'b0, e);
    do_access(16'h0123, 1'b0, st, d, v);
    chk("wait3_stalls", st, 17);
    chk("wait3_instr", d, 16'hA486);
    chk("wait3_valid", v, 1);
    waits = 0;
    check_access("hit_prep", 16'h0100, 1'b0);
    check_access("hit_again", 16'h0100, 1'b0);
    bus.inval = 1'b1;
    #1;
    chk("inval_hit_cycle_valid", bus.instr_valid, 1);
    model_access(16'h0100, 1'b1, e);
    do_access(16'h0100, 1'b1, st, d, v);
    chk("inval_next_stalls", st, 5);
    chk("inval_next_instr", d, 16'h0100 ^ 16'hA5A5);
    a = 16'h0200;
    ackq.delete();
    bus.fetch_addr = a;
    @(posedge clk); #1;
    n = 0;
    while (bus.stall && n < 400) begin
      if (n == 2) bus.inval = 1'b1;
      @(posedge clk); #1;
      bus.inval = 1'b0;
      n++;
    end
    chk("midfill_inval_stalls", n, 10);
    chk("midfill_inval_instr", bus.instr, a ^ 16'hA5A5);
    chk("midfill_inval_valid", bus.instr_valid, 1);
    exp_q = '{16'h0200, 16'h0201, 16'h0202, 16'h0203, 16'h0200, 16'h0201, 16'h0202, 16'h0203};
    chk("midfill_refetch_addrs", ackq == exp_q, 1);
    model_reset();
    model_access(a, 1'b0, e);
    for (int i = 0; i < 150; i++) begin
      waits = $urandom_range(0, 2);
      a = 16'($urandom_range(0, 511));
      check_access($sformatf("rnd%0d", i), a, $urandom_range(0, 15) == 0);
    end
    waits = 0;
    check_access("pre_reset_fill", 16'h8010, 1'b0);
    bus.fetch_addr = 16'h8020;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midfill_rst_mem_req", bus.mem_req, 0);
    chk("midfill_rst_stall", bus.stall, 0);
    chk("midfill_rst_mem_addr", bus.mem_addr, 0);
    #2 rst_n = 1'b1;
    model_reset();
    check_access("post_reset_miss", 16'h8010, 1'b0);
    chk("handshake_stable", hs_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache serving the two-stage fetch front end. Each cycle it samples the fetch word address and, one cycle later, returns the instruction with a valid flag. On a miss it raises `stall`, which makes the fetch stage replay the missed address. It then fills the whole line from backing memory over a req/ack word handshake and resumes.

## Interface
- `LINE_WORDS`, 4: 16-bit words per line; power of two, at least 2.
- `NUM_LINES`, 16: number of lines; power of two.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fetch_addr`  in  16  word address from the fetch stage, sampled every unstalled edge.
- `inval`  in  1  invalidate all lines; synchronous, one-cycle pulse.
- `instr`  out  16  instruction for the sampled address; 16'h0000 whenever `instr_valid`=0.
- `instr_valid`  out  1  `instr` is good this cycle.
- `stall`  out  1  the fetch stage must hold; combinational from registered state.
- `mem_req`  out  1  word read request to backing memory.
- `mem_addr`  out  16  word address of the request.
- `mem_ack`  in  1  memory returns data this cycle; ignored unless `mem_req`=1.
- `mem_data`  in  16  read data, valid with `mem_ack`.

## Operation
- Address split uses the registered request address `raddr`:
  - offset = low log2(`LINE_WORDS`) bits;
  - index = next log2(`NUM_LINES`) bits;
  - tag = remaining bits (10 bits at the defaults).
- Storage:
  - data array of `NUM_LINES`×`LINE_WORDS` words;
  - per line: a tag and a valid bit.
- `hit` = valid[index] && tag matches && state==LOOKUP.
- `primed` register: 0 at reset, 1 after the first edge following reset release.
- States:
  - LOOKUP
    - `raddr` <= `fetch_addr` on every edge where `stall`=0; `raddr` is frozen while `stall`=1.
    - If `primed` and not `hit`: `stall`=1; next state is FILL with word counter `cnt`=0 and `inval_seen`=0.
  - FILL
    - Outputs: `mem_req`=1, `mem_addr`={raddr tag, raddr index, `cnt`}, `stall`=1.
    - On an edge with `mem_ack`=1: write `mem_data` to data[index][cnt] and increment `cnt`.
    - On the ack of the last word (`cnt`==`LINE_WORDS`-1): write the tag; set valid only if `inval_seen`=0; return to LOOKUP.
- Outputs:
  - `instr_valid` = `primed` && `hit`.
  - `stall` = `primed` && !`hit`.
- Fill order is word 0 upward; there is no critical-word-first.
- `inval`:
  - clears every valid bit at the edge;
  - during FILL it also sets `inval_seen`, so the line being filled is written but left invalid. The re-lookup then misses and refetches.
- No write port. Stores to instruction memory must be followed by `inval`.

## Timing
- Reset, asynchronous while `rst_n`=0:
  - state=LOOKUP, all valid bits=0, `raddr`=0, `cnt`=0, `primed`=0;
  - outputs `instr`=0, `instr_valid`=0, `stall`=0, `mem_req`=0, `mem_addr`=0.
- Reset mid-fill abandons the fill and drops `mem_req` immediately. Backing memory must tolerate the abandoned request.
- Hit latency: `fetch_addr` sampled at edge k gives `instr`/`instr_valid` in the cycle after edge k.
- Miss penalty:
  - 1 detect cycle plus one FILL cycle per word-handshake cycle;
  - with zero-wait memory (`mem_ack`=1 in the cycle `mem_req` rises) `stall` is high for 1+`LINE_WORDS` = 5 cycles.
- Handshake rules:
  - `mem_req` and `mem_addr` stay stable until the edge on which `mem_ack`=1;
  - `mem_req` stays high between consecutive words of one fill;
  - it drops on the edge that captures the last word.
- The first cycle `stall` falls after a fill always shows `instr_valid`=1 for the replayed address.
- `inval` in the same cycle as a hit: that cycle's output is still valid; the next access misses.

## Test plan
- Reset with `fetch_addr`=0, memory returning `mem_data`=addr^16'hA5A5 with zero wait:
  - first cycle after release: `instr_valid`=0 and `stall`=0;
  - then `stall`=1 for 5 cycles, with `mem_addr` stepping 0,1,2,3;
  - then `instr`=16'hA5A5 with `instr_valid`=1.
- Sequential fetch 0x0001..0x0003 after that fill: zero stall cycles; `instr` = 0xA5A4, 0xA5A7, 0xA5A6 on consecutive cycles.
- Conflict (same index 0, tags 0 and 1):
  - fetch 0x0040 misses and `mem_addr` runs 0x0040..0x0043;
  - fetch 0x0000 then misses again.
- Memory with 3 wait cycles before each ack:
  - `mem_req` and `mem_addr` held stable through the waits;
  - `stall` high for 17 cycles;
  - the correct word is returned.
- `inval` pulsed during the second word of a fill:
  - the fill completes, then LOOKUP misses and refetches the same 4 addresses;
  - after the refetch, `instr_valid`=1.
- `rst_n` asserted during the third fill word: `mem_req`=0 and `stall`=0 immediately; after release, the previously filled line misses.
